// File: rtl/fifo_read_ctrl.sv
// Burst read controller: pops N words from a synchronous FIFO through a
// 2-entry output buffer onto a valid/ready stream, with abort and sticky underflow.
module fifo_read_ctrl #(
    parameter int WIDTH     = 8,
    parameter int FIFO_SIZE = 16,
    parameter int PTR       = $clog2(FIFO_SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PTR:0]     burst_len,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             fifo_empty,
    input  logic             fifo_underflow,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [PTR:0]     rd_count,
    output logic             err_underflow
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [PTR:0] ONE = {{PTR{1'b0}}, 1'b1};

    state_t           state;
    logic [PTR:0]     remaining;
    logic [1:0]       occ;
    logic             inflight;
    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             pop;
    logic             active;
    logic [2:0]       load;

    assign m_valid = (occ != 2'd0);
    assign m_data  = entry0;
    assign pop     = m_valid && m_ready;
    assign active  = (state == RUN) || (state == FLUSH);

    // The word leaving this cycle frees its slot, so reads can issue back to back.
    assign load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = (state == RUN) && !fifo_empty &&
                        (remaining != '0) && (load < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remaining     <= '0;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            entry0        <= '0;
            entry1        <= '0;
            rd_count      <= '0;
            err_underflow <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && active) begin
                state     <= IDLE;
                busy      <= 1'b0;
                occ       <= 2'd0;
                inflight  <= 1'b0;
                remaining <= '0;
            end else begin
                inflight <= fifo_rd_en;
                occ      <= load[1:0];
                if (fifo_rd_en) begin
                    remaining <= remaining - ONE;
                    rd_count  <= rd_count + ONE;
                end
                // entry0 is always the oldest word
                case ({inflight, pop})
                    2'b10: begin
                        if (occ == 2'd0) entry0 <= fifo_rdata;
                        else             entry1 <= fifo_rdata;
                    end
                    2'b01: entry0 <= entry1;
                    2'b11: begin
                        if (occ == 2'd2) begin
                            entry0 <= entry1;
                            entry1 <= fifo_rdata;
                        end else begin
                            entry0 <= fifo_rdata;
                        end
                    end
                    default: ;
                endcase
                case (state)
                    IDLE: begin
                        if (start) begin
                            remaining <= burst_len;
                            rd_count  <= '0;
                            if (burst_len == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (remaining == '0) state <= FLUSH;
                    end
                    FLUSH: begin
                        if (occ == 2'd0 && !inflight) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (fifo_underflow)
                err_underflow <= 1'b1;
            else if (start && state == IDLE)
                err_underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: queue-based FIFO model feeds the DUT,
// written words are expected back in order on the valid/ready stream.
module tb_fifo_read_ctrl;
    localparam int WIDTH     = 8;
    localparam int FIFO_SIZE = 16;
    localparam int PTR       = $clog2(FIFO_SIZE);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [PTR:0]     burst_len;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rdata = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_underflow;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic             busy;
    logic             done;
    logic [PTR:0]     rd_count;
    logic             err_underflow;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] wr_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             flush_req;
    logic             rnd_ready;

    int               xfer_cnt = 0;
    int               rd_cnt = 0;
    int               done_cnt = 0;
    int               out_cnt = 0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    int               first_tick;
    int               last_tick;

    always #5 clk = ~clk;

    fifo_read_ctrl #(
        .WIDTH(WIDTH),
        .FIFO_SIZE(FIFO_SIZE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .burst_len(burst_len),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow),
        .m_valid(m_valid),
        .m_data(m_data),
        .m_ready(m_ready),
        .busy(busy),
        .done(done),
        .rd_count(rd_count),
        .err_underflow(err_underflow)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Synchronous FIFO with one-cycle read latency; writes land at the edge.
    always @(posedge clk) begin
        if (flush_req) begin
            fifo_q.delete();
        end else if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_rdata <= fifo_q.pop_front();
        end
        while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Monitor: every value here is the one the next rising edge will sample.
    always @(negedge clk) begin
        if (reset) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(m_valid), 1);
                check("stall_data", int'(m_data), int'(prev_data));
            end
            if (fifo_rd_en) begin
                rd_cnt++;
                check("rd_when_empty", int'(fifo_empty), 0);
            end
            if (m_valid && m_ready) begin
                xfer_cnt++;
                check("beat_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    check("beat_data", int'(m_data), int'(exp_q.pop_front()));
            end
            if (done) done_cnt++;
            if (abort) begin
                out_cnt = 0;
            end else begin
                out_cnt += int'(fifo_rd_en) - int'(m_valid && m_ready);
                if (fifo_rd_en) check("outstanding_le2", int'(out_cnt <= 2), 1);
            end
            prev_stall = m_valid && !m_ready && !abort;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_words(input int n);
        logic [WIDTH-1:0] b;
        for (int i = 0; i < n; i++) begin
            b = WIDTH'($urandom);
            wr_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic cleanup();
        flush_req = 1'b1;
        exp_q.delete();
        tick();
        flush_req = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        burst_len = (PTR+1)'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int xp;
        bit ok;
        d0 = done_cnt;
        xp = xfer_cnt;
        ok = 1'b0;
        first_tick = -1;
        last_tick  = -1;
        for (int i = 0; i < budget; i++) begin
            if (xfer_cnt != xp) begin
                if (first_tick < 0) first_tick = i;
                last_tick = i;
                xp = xfer_cnt;
            end
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_done_seen"}, int'(ok), 1);
        tick();
        tick();
        check({name, "_single_done"}, done_cnt - d0, 1);
        check({name, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int r0;
        int d0;
        int x0;
        int len;
        reset          = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        burst_len      = '0;
        m_ready        = 1'b1;
        fifo_underflow = 1'b0;
        flush_req      = 1'b0;
        rnd_ready      = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_count", int'(rd_count), 0);
        check("rst_err", int'(err_underflow), 0);
        check("rst_rd_en", int'(fifo_rd_en), 0);
        tick();
        reset = 1'b0;
        tick();

        // basic drain at full throughput
        push_words(16);
        pulse_start(16);
        wait_done("drain", 200);
        check("drain_gapless", last_tick - first_tick, 15);
        check("drain_left", exp_q.size(), 0);
        check("drain_rd_count", int'(rd_count), 16);
        check("drain_err", int'(err_underflow), 0);

        // backpressure
        push_words(8);
        rnd_ready = 1'b1;
        pulse_start(8);
        wait_done("bp", 400);
        rnd_ready = 1'b0;
        m_ready   = 1'b1;
        check("bp_left", exp_q.size(), 0);
        check("bp_rd_count", int'(rd_count), 8);

        // starved FIFO
        push_words(2);
        r0 = rd_cnt;
        pulse_start(4);
        repeat (20) tick();
        @(negedge clk);
        check("starve_busy", int'(busy), 1);
        check("starve_rd_en", int'(fifo_rd_en), 0);
        check("starve_rd_count", int'(rd_count), 2);
        check("starve_reads", rd_cnt - r0, 2);
        tick();
        push_words(2);
        wait_done("starve", 200);
        check("starve_rd_count_end", int'(rd_count), 4);
        check("starve_left", exp_q.size(), 0);

        // zero-length burst
        r0 = rd_cnt;
        pulse_start(0);
        @(negedge clk);
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        tick();
        @(negedge clk);
        check("zero_done_drop", int'(done), 0);
        check("zero_reads", rd_cnt - r0, 0);
        check("zero_rd_count", int'(rd_count), 0);
        tick();

        // start during RUN is ignored
        push_words(6);
        pulse_start(4);
        burst_len = (PTR+1)'(15);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_done("ign", 200);
        check("ign_rd_count", int'(rd_count), 4);
        check("ign_left", exp_q.size(), 2);
        repeat (3) tick();
        check("ign_stay_idle", int'(busy), 0);
        cleanup();

        // abort after 3 delivered words
        push_words(10);
        pulse_start(10);
        x0 = xfer_cnt;
        for (int i = 0; i < 100 && (xfer_cnt - x0) < 3; i++) tick();
        check("abort_reached3", xfer_cnt - x0, 3);
        d0      = done_cnt;
        abort   = 1'b1;
        m_ready = 1'b0;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_m_valid", int'(m_valid), 0);
        check("abort_busy", int'(busy), 0);
        repeat (4) tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_delivered", xfer_cnt - x0, 3);
        m_ready = 1'b1;
        cleanup();

        // reset mid-burst, with an underflow flagged beforehand
        push_words(10);
        m_ready = 1'b0;
        pulse_start(10);
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("midrst_pre_err", int'(err_underflow), 1);
        check("midrst_pre_valid", int'(m_valid), 1);
        d0 = done_cnt;
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_m_data", int'(m_data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_rd_count", int'(rd_count), 0);
        check("midrst_err", int'(err_underflow), 0);
        check("midrst_rd_en", int'(fifo_rd_en), 0);
        tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        check("midrst_no_done", done_cnt - d0, 0);
        cleanup();

        // sticky underflow while idle
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        @(negedge clk);
        check("uf_set", int'(err_underflow), 1);
        repeat (5) tick();
        @(negedge clk);
        check("uf_hold", int'(err_underflow), 1);
        tick();
        pulse_start(0);
        @(negedge clk);
        check("uf_clear_on_start", int'(err_underflow), 0);
        repeat (2) tick();

        // random bursts under random backpressure
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 16);
            push_words(len);
            rnd_ready = 1'b1;
            pulse_start(len);
            wait_done("rand", 500);
            rnd_ready = 1'b0;
            m_ready   = 1'b1;
            check("rand_rd_count", int'(rd_count), len);
            check("rand_left", exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
